// File: rtl/ps2_scan_rx.sv
// ---------------------------------------------------------------------------
// ps2_scan_rx
//
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
// stop) on the system clock and decodes the byte stream into scan codes and
// make codes. Both keyboard lines are raw, asynchronous inputs; they are
// synchronised here and the receiver advances only on detected falling edges
// of the keyboard clock.
//
// Parameters
//   TIMEOUT_CYCLES  clk cycles without a keyboard_clk falling edge that abort
//                   a partially received frame
//   PARITY_CHECK    1: frames with bad odd parity are discarded
//                   0: the parity bit is ignored
//
// Ports
//   clk            system clock, all state changes on its rising edge
//   reset_n        asynchronous active-low reset
//   keyboard_clk   raw PS/2 clock (asynchronous)
//   keyboard_data  raw PS/2 data (asynchronous)
//   scan_code      last correctly received byte, held until the next good one
//   scan_valid     one-cycle pulse when scan_code updates
//   make_code      last make code (prefixes F0/E0 and break codes excluded)
//   make_valid     one-cycle pulse when make_code updates
//   frame_error    one-cycle pulse on bad stop bit, bad parity or timeout
//
// Receiver states
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | waiting for a falling edge with data low (start bit)
//   ST_DATA    | shifting in the 8 data bits, LSB first
//   ST_PARITY  | next falling edge captures the parity bit
//   ST_STOP    | next falling edge checks the stop bit and ends the frame
// ---------------------------------------------------------------------------
module ps2_scan_rx #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int PARITY_CHECK   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       keyboard_clk,
    input  logic       keyboard_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic [7:0] make_code,
    output logic       make_valid,
    output logic       frame_error
);

    localparam int               TMO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       CODE_BREAK = 8'hF0;
    localparam logic [7:0]       CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // synchronizers; kclk_prev_q holds the synced clock of the previous cycle
    logic kclk_meta_q, kclk_meta_d;
    logic kclk_sync_q, kclk_sync_d;
    logic kclk_prev_q, kclk_prev_d;
    logic kdat_meta_q, kdat_meta_d;
    logic kdat_sync_q, kdat_sync_d;

    // frame receiver
    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // decoder and outputs
    logic [7:0] scan_code_q, scan_code_d;
    logic       scan_valid_q, scan_valid_d;
    logic [7:0] make_code_q, make_code_d;
    logic       make_valid_q, make_valid_d;
    logic       frame_error_q, frame_error_d;
    logic       break_pend_q, break_pend_d;
    logic       ext_pend_q, ext_pend_d;

    logic kclk_fall;
    logic tmo_hit;
    logic frame_done;
    logic frame_good;
    logic parity_ok;

    // -----------------------------------------------------------------------
    // Input synchronisation and edge detection
    // -----------------------------------------------------------------------
    always_comb begin
        kclk_meta_d = keyboard_clk;
        kclk_sync_d = kclk_meta_q;
        kclk_prev_d = kclk_sync_q;
        kdat_meta_d = keyboard_data;
        kdat_sync_d = kdat_meta_q;
    end

    assign kclk_fall = kclk_prev_q & ~kclk_sync_q;

    // -----------------------------------------------------------------------
    // Frame receiver
    // -----------------------------------------------------------------------
    // Odd parity over data plus parity bit: XOR of all nine bits must be 1.
    assign parity_ok = (^shift_q) ^ parity_q;

    // A timeout wins over a falling edge arriving in the same cycle.
    assign tmo_hit = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        frame_done = 1'b0;
        frame_good = 1'b0;

        if (tmo_hit) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
        end else if (kclk_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!kdat_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d = {kdat_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = ST_PARITY;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    parity_d = kdat_sync_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                    frame_good = kdat_sync_q && ((PARITY_CHECK == 0) || parity_ok);
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end
            endcase
        end

        if ((state_q == ST_IDLE) || kclk_fall || tmo_hit) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Scan-code decoder
    // -----------------------------------------------------------------------
    // Prefix bytes only arm the pending flags. A byte following F0 is the
    // release of a key: it consumes both flags without reporting a make.
    always_comb begin
        scan_code_d   = scan_code_q;
        make_code_d   = make_code_q;
        break_pend_d  = break_pend_q;
        ext_pend_d    = ext_pend_q;
        scan_valid_d  = 1'b0;
        make_valid_d  = 1'b0;
        frame_error_d = tmo_hit | (frame_done & ~frame_good);

        if (frame_done && frame_good) begin
            scan_code_d  = shift_q;
            scan_valid_d = 1'b1;
            if (shift_q == CODE_BREAK) begin
                break_pend_d = 1'b1;
            end else if (shift_q == CODE_EXT) begin
                ext_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                if (break_pend_q) begin
                    break_pend_d = 1'b0;
                end else begin
                    make_code_d  = shift_q;
                    make_valid_d = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kclk_meta_q   <= 1'b1;
            kclk_sync_q   <= 1'b1;
            kclk_prev_q   <= 1'b1;
            kdat_meta_q   <= 1'b1;
            kdat_sync_q   <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            parity_q      <= 1'b0;
            tmo_cnt_q     <= '0;
            scan_code_q   <= 8'h00;
            scan_valid_q  <= 1'b0;
            make_code_q   <= 8'h00;
            make_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            break_pend_q  <= 1'b0;
            ext_pend_q    <= 1'b0;
        end else begin
            kclk_meta_q   <= kclk_meta_d;
            kclk_sync_q   <= kclk_sync_d;
            kclk_prev_q   <= kclk_prev_d;
            kdat_meta_q   <= kdat_meta_d;
            kdat_sync_q   <= kdat_sync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tmo_cnt_q     <= tmo_cnt_d;
            scan_code_q   <= scan_code_d;
            scan_valid_q  <= scan_valid_d;
            make_code_q   <= make_code_d;
            make_valid_q  <= make_valid_d;
            frame_error_q <= frame_error_d;
            break_pend_q  <= break_pend_d;
            ext_pend_q    <= ext_pend_d;
        end
    end

    assign scan_code   = scan_code_q;
    assign scan_valid  = scan_valid_q;
    assign make_code   = make_code_q;
    assign make_valid  = make_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 5000, giving the clk cycles without a keyboard_clk falling edge that abort a partial frame.
REQ-002 The block SHALL have parameter PARITY_CHECK, default 1; 1 discards frames with bad odd parity, 0 ignores the parity bit.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port keyboard_clk, input, 1, raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 The block SHALL have port keyboard_data, input, 1, raw PS/2 data, asynchronous to clk.
REQ-007 The block SHALL have port scan_code, output, 8, the last correctly received frame byte, held until the next good frame.
REQ-008 The block SHALL have port scan_valid, output, 1, a one-cycle pulse when scan_code updates.
REQ-009 The block SHALL have port make_code, output, 8, the last make code, excluding prefixes F0/E0 and break codes.
REQ-010 The block SHALL have port make_valid, output, 1, a one-cycle pulse when make_code updates.
REQ-011 The block SHALL have port frame_error, output, 1, a one-cycle pulse on a bad stop bit, bad parity (PARITY_CHECK=1) or timeout.

Function
REQ-012 keyboard_clk and keyboard_data SHALL each pass through a 2-flop synchronizer; a falling edge is synced clock 1 in the previous cycle and 0 in this cycle.
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY and STOP, and act only on detected falling edges, sampling synced data in the same cycle.
REQ-014 In IDLE, an edge with data 0 (start bit) SHALL go to DATA with bit count 0; an edge with data 1 SHALL be ignored and the FSM stays in IDLE.
REQ-015 In DATA, each edge SHALL shift data in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-016 In PARITY, the edge SHALL capture the parity bit and go to STOP; a frame is parity-good when data bits plus parity contain an odd number of ones.
REQ-017 In STOP, the edge SHALL return to IDLE; if stop=1 and parity passes (or PARITY_CHECK=0), scan_code updates and scan_valid pulses, otherwise only frame_error pulses.
REQ-018 Latency: scan_valid SHALL be high exactly 2 clk cycles after the rising clk edge that first samples the stop-bit keyboard_clk low.
REQ-019 A timeout counter SHALL clear on every falling edge and in IDLE; if it reaches TIMEOUT_CYCLES-1 outside IDLE, the FSM SHALL go to IDLE and pulse frame_error once.
REQ-020 A timeout edge SHALL take priority over a simultaneous falling edge in the same cycle.
REQ-021 Decoder: a good frame F0 SHALL set break_pending; E0 SHALL set ext_pending; neither SHALL pulse make_valid.
REQ-022 A good frame other than F0/E0 with break_pending clear SHALL update make_code and pulse make_valid in the same cycle as scan_valid.
REQ-023 A good frame other than F0/E0 with break_pending set SHALL clear both pending flags and SHALL NOT pulse make_valid.
REQ-024 Any good non-prefix frame SHALL clear ext_pending; errored frames SHALL leave both pending flags unchanged.
REQ-025 scan_valid, make_valid and frame_error SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-026 While reset_n=0: FSM=IDLE, bit count, timeout counter, shift register, scan_code, make_code = 0; scan_valid, make_valid, frame_error, both pending flags = 0; synchronizer flops = 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output pulses; reception restarts at the next start bit after release.

Verification
REQ-028 Frame 0x1C, parity 0, stop 1 -> scan_code=0x1C; scan_valid and make_valid one cycle each; make_code=0x1C; frame_error=0.
REQ-029 Sequence 0x1C, 0xF0, 0x1C (correct parity) -> three scan_valid pulses, exactly one make_valid; break_pending=0 at end.
REQ-030 Frame 0x1C with parity 1, PARITY_CHECK=1 -> frame_error pulse; scan_code keeps its prior value; no scan_valid; with PARITY_CHECK=0 -> scan_code=0x1C.
REQ-031 Start plus 4 data bits then keyboard_clk held high for 5000 cycles -> one frame_error pulse; the next full 0x32 frame is received correctly.
REQ-032 Stop bit driven 0 on frame 0x45 -> frame_error pulse; no scan_valid; FSM returns to IDLE.
REQ-033 reset_n pulsed low after the 5th data bit -> all outputs 0, no pulses; the following full 0x16 frame yields scan_code=0x16 and make_valid.
